// File: rtl/dct_mac_sequencer_if.sv
// dct_mac_sequencer_if
//   Bundles the row input handshake, the MAC control/result lines and the
//   result output handshake of the DCT MAC sequencer.
//   Ports (signals):
//     s_valid/s_ready/s_data      : row input, sample k in s_data[k*DW +: DW]
//     mac_clr/mac_en/mac_x/mac_tap: MAC control towards the multiply-accumulate unit
//     mac_result                  : MAC accumulator output back to the sequencer
//     m_valid/m_ready/m_data      : captured result towards downstream
//   Modports:
//     master : the sequencer side
//     slave  : the environment side (row source, MAC unit, result sink)
interface dct_mac_sequencer_if #(
  parameter int DW   = 8,
  parameter int TAPS = 8,
  parameter int RW   = 32
);
  localparam int KW = $clog2(TAPS);

  logic               s_valid;
  logic               s_ready;
  logic [DW*TAPS-1:0] s_data;
  logic               mac_clr;
  logic               mac_en;
  logic [DW-1:0]      mac_x;
  logic [KW-1:0]      mac_tap;
  logic [RW-1:0]      mac_result;
  logic               m_valid;
  logic               m_ready;
  logic [RW-1:0]      m_data;

  modport master (
    input  s_valid, s_data, mac_result, m_ready,
    output s_ready, mac_clr, mac_en, mac_x, mac_tap, m_valid, m_data
  );

  modport slave (
    output s_valid, s_data, mac_result, m_ready,
    input  s_ready, mac_clr, mac_en, mac_x, mac_tap, m_valid, m_data
  );
endinterface

// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer
//   Control sequencer for one DCT MAC unit. Accepts one row of TAPS samples,
//   steps the shared MAC through TAPS multiply-accumulate cycles (clear on
//   the first tap), waits out the MAC pipeline latency, captures the
//   accumulator bit-exact and holds it on a valid/ready output.
//   Ports:
//     clk    : clock, all state changes on the rising edge
//     rst    : synchronous active-high reset, wins over ena_i
//     ena_i  : global clock enable; low freezes every register
//     busy_o : high whenever the sequencer is not idle
//     bus    : dct_mac_sequencer_if master modport (row in, MAC control, result out)
module dct_mac_sequencer #(
  parameter int DW      = 8,
  parameter int TAPS    = 8,
  parameter int RW      = 32,
  parameter int MAC_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena_i,
  output logic                       busy_o,
  dct_mac_sequencer_if.master        bus
);

  localparam int KW = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  // Unused when MAC_LAT is 0 because WAIT is then never entered.
  localparam logic [2:0] LAT_LAST = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_WAIT,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t             state_q,  state_d;
  logic [KW-1:0]      k_q,      k_d;
  logic [2:0]         lat_q,    lat_d;
  logic [DW*TAPS-1:0] samp_q,   samp_d;
  logic               macEn_q,  macEn_d;
  logic               macClr_q, macClr_d;
  logic [KW-1:0]      macTap_q, macTap_d;
  logic [DW-1:0]      macX_q,   macX_d;
  logic               mValid_q, mValid_d;
  logic [RW-1:0]      mData_q,  mData_d;
  logic [KW-1:0]      kNext;

  assign kNext = k_q + KW'(1);

  // Next-state logic. The MAC controls are registered, so while in MAC with
  // tap k presented, this computes the controls for tap k+1. The row's first
  // tap is therefore issued directly from s_data on the accepting edge.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    lat_d    = lat_q;
    samp_d   = samp_q;
    macEn_d  = 1'b0;
    macClr_d = 1'b0;
    macTap_d = '0;
    macX_d   = '0;
    mValid_d = mValid_q;
    mData_d  = mData_q;

    case (state_q)
      S_IDLE: begin
        if (bus.s_valid) begin
          samp_d   = bus.s_data;
          k_d      = '0;
          macEn_d  = 1'b1;
          macClr_d = 1'b1;
          macX_d   = bus.s_data[DW-1:0];
          state_d  = S_MAC;
        end
      end

      S_MAC: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          lat_d   = '0;
          state_d = (MAC_LAT == 0) ? S_CAPTURE : S_WAIT;
        end else begin
          k_d      = kNext;
          macEn_d  = 1'b1;
          macTap_d = kNext;
          macX_d   = samp_q[kNext*DW +: DW];
        end
      end

      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      S_CAPTURE: begin
        mData_d  = bus.mac_result;
        mValid_d = 1'b1;
        state_d  = S_OUT;
      end

      S_OUT: begin
        if (bus.m_ready) begin
          mValid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register. With ena_i low nothing moves, which is what lets a
  // stalled tap be reissued exactly once when the enable returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      lat_q    <= '0;
      samp_q   <= '0;
      macEn_q  <= 1'b0;
      macClr_q <= 1'b0;
      macTap_q <= '0;
      macX_q   <= '0;
      mValid_q <= 1'b0;
      mData_q  <= '0;
    end else if (ena_i) begin
      state_q  <= state_d;
      k_q      <= k_d;
      lat_q    <= lat_d;
      samp_q   <= samp_d;
      macEn_q  <= macEn_d;
      macClr_q <= macClr_d;
      macTap_q <= macTap_d;
      macX_q   <= macX_d;
      mValid_q <= mValid_d;
      mData_q  <= mData_d;
    end
  end

  // The MAC must not operate and no row may be taken while the block is
  // frozen or being reset, so those strobes are gated combinationally.
  assign bus.s_ready = (state_q == S_IDLE) && ena_i && !rst;
  assign bus.mac_en  = macEn_q && ena_i;
  assign bus.mac_clr = macClr_q && ena_i;
  assign bus.mac_tap = macTap_q;
  assign bus.mac_x   = macX_q;
  assign bus.m_valid = mValid_q;
  assign bus.m_data  = mData_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
